// File: rtl/pulse_train_gen.sv
// Multi-channel pulse train generator: per-channel one-shot, fixed-rate repeat or
// typematic strobes from level inputs, with runtime period and delay.
module pulse_train_gen #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in,
  input  logic [1:0]          mode,
  input  logic [CNT_W-1:0]    period,
  input  logic [CNT_W-1:0]    delay,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] active
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REPEAT
  } state_t;

  localparam logic [1:0] MODE_REPEAT    = 2'd1;
  localparam logic [1:0] MODE_TYPEMATIC = 2'd2;

  state_t                 state   [CHANNELS];
  logic [CNT_W-1:0]       cnt     [CHANNELS];
  logic [CNT_W-1:0]       per_m1  [CHANNELS];
  logic [CHANNELS-1:0]    prev;

  logic [CNT_W-1:0]       period_m1;
  logic [CNT_W-1:0]       delay_m1;

  // Counters hold "cycles still to wait", so a spacing of S loads S-1; zero spacing acts as 1.
  always_comb begin
    period_m1 = '0;
    delay_m1  = '0;
    if (period != '0) period_m1 = period - 1'b1;
    if (delay != '0)  delay_m1  = delay - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev   <= '1;
      out    <= '0;
      active <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state[i]  <= ST_IDLE;
        cnt[i]    <= '0;
        per_m1[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        prev[i] <= in[i];
        out[i]  <= 1'b0;
        if (in[i] && !prev[i]) begin
          // The latched mode lives on as the state; the delay is consumed at load.
          out[i]    <= 1'b1;
          per_m1[i] <= period_m1;
          case (mode)
            MODE_REPEAT: begin
              state[i]  <= ST_REPEAT;
              cnt[i]    <= period_m1;
              active[i] <= 1'b1;
            end
            MODE_TYPEMATIC: begin
              state[i]  <= ST_WAIT;
              cnt[i]    <= delay_m1;
              active[i] <= 1'b1;
            end
            default: begin
              state[i]  <= ST_IDLE;
              cnt[i]    <= '0;
              active[i] <= 1'b0;
            end
          endcase
        end else if (!in[i]) begin
          state[i]  <= ST_IDLE;
          cnt[i]    <= '0;
          active[i] <= 1'b0;
        end else if (state[i] != ST_IDLE) begin
          if (cnt[i] == '0) begin
            out[i]   <= 1'b1;
            cnt[i]   <= per_m1[i];
            state[i] <= ST_REPEAT;
          end else begin
            cnt[i] <= cnt[i] - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: pulse-time arithmetic model checked every
// cycle, directed scenarios with literal pulse masks, then randomized traffic.
module tb_pulse_train_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in;
  logic [1:0] mode;
  logic [7:0] period;
  logic [7:0] delay;
  logic [3:0] out;
  logic [3:0] active;

  int n_checks = 0;
  int n_fail   = 0;

  pulse_train_gen #(.CHANNELS(4), .CNT_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .mode   (mode),
    .period (period),
    .delay  (delay),
    .out    (out),
    .active (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a held channel pulses at n cycles after its edge (n = 0 is the first pulse).
  function automatic bit pulse_due(input int n, input int m, input int p, input int d);
    if (n == 0) return 1'b1;
    if (m == 1) return (n % p) == 0;
    if (m == 2) return (n == d) || (n > d && ((n - d) % p) == 0);
    return 1'b0;
  endfunction

  int         e_cnt = 0;
  int         k_edge [4];
  int         m_mode [4];
  int         m_per  [4];
  int         m_dly  [4];
  bit         held   [4];
  logic [3:0] m_prev;
  logic [3:0] exp_out = '0;
  logic [3:0] exp_act = '0;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    e_cnt++;
    chk_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (rst) begin
        held[c]    = 1'b0;
        m_prev[c]  = 1'b1;
        exp_out[c] = 1'b0;
        exp_act[c] = 1'b0;
      end else begin
        if (in[c] && !m_prev[c]) begin
          held[c]   = 1'b1;
          k_edge[c] = e_cnt;
          m_mode[c] = int'(mode);
          m_per[c]  = (period == 0) ? 1 : int'(period);
          m_dly[c]  = (delay == 0) ? 1 : int'(delay);
        end else if (!in[c]) begin
          held[c] = 1'b0;
        end
        m_prev[c]  = in[c];
        exp_out[c] = held[c] && pulse_due(e_cnt - k_edge[c], m_mode[c], m_per[c], m_dly[c]);
        exp_act[c] = held[c] && (m_mode[c] == 1 || m_mode[c] == 2);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_out", 64'(out), 64'(exp_out));
      check("model_active", 64'(active), 64'(exp_act));
    end
  end

  task automatic capture(input int ch, input int n, output logic [63:0] om, output logic [63:0] am);
    om = '0;
    am = '0;
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      om[j] = out[ch];
      am[j] = active[ch];
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [63:0] om, am;
  int          cnt0;

  initial begin
    rst = 1'b1; in = 4'b0001; mode = 2'd1; period = 8'd3; delay = 8'd1;
    cyc(3);
    rst = 1'b0;

    // Input held high through reset must not fire.
    cnt0 = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (out != 4'b0000) cnt0++;
    end
    check("held_at_reset_silent", 64'(cnt0), 64'd0);
    in = 4'b0000; cyc(1);
    in = 4'b0001;
    capture(0, 8, om, am);
    check("repeat_p3_out", om, 64'h92);
    check("repeat_p3_active", am, 64'h1FE);
    in = 4'b0000; cyc(2);

    // One-shot
    mode = 2'd0;
    in = 4'b0010;
    capture(1, 20, om, am);
    check("oneshot_out", om, 64'h2);
    check("oneshot_active", am, 64'h0);
    in = 4'b0000; cyc(2);

    // Typematic D=10, P=4, held for 30 sampled edges
    mode = 2'd2; delay = 8'd10; period = 8'd4;
    in = 4'b0100;
    capture(2, 30, om, am);
    check("typematic_out", om, 64'h0888_8802);
    check("typematic_active", am, 64'h7FFF_FFFE);
    in = 4'b0000;
    capture(2, 10, om, am);
    check("typematic_release_out", om, 64'h0);
    check("typematic_release_active", am, 64'h0);

    // P=0 and P=1 both give continuous output; later period change ignored
    mode = 2'd1; period = 8'd0;
    in = 4'b0001; cyc(1);
    period = 8'd1;
    in = 4'b1001;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("continuous_p01", 64'(out), 64'h9);
    end
    period = 8'd5;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("continuous_after_period_change", 64'(out), 64'h9);
    end
    in = 4'b0000; cyc(1);
    check("continuous_release_out", 64'(out), 64'h0);
    check("continuous_release_active", 64'(active), 64'h0);
    cyc(2);

    // Simultaneous edges, P=2; ch1 released; reset mid-train
    mode = 2'd1; period = 8'd2;
    in = 4'b1111;
    cyc(1);
    check("simul_first", 64'(out), 64'hF);
    cyc(1);
    check("simul_gap", 64'(out), 64'h0);
    cyc(3);
    check("simul_third", 64'(out), 64'hF);
    in = 4'b1101;
    cyc(2);
    check("simul_ch1_stopped", 64'(out), 64'hD);
    check("simul_active", 64'(active), 64'hD);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    check("midreset_out", 64'(out), 64'h0);
    check("midreset_active", 64'(active), 64'h0);
    rst = 1'b0;
    cyc(6);
    check("midreset_held_silent", 64'(out), 64'h0);
    in = 4'b0000; cyc(2);

    // Randomized traffic against the model
    for (int j = 0; j < 3000; j++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 5) == 0) in[c] = ~in[c];
      mode   = 2'($urandom_range(0, 3));
      period = 8'($urandom_range(0, 6));
      delay  = 8'($urandom_range(0, 9));
      rst    = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
